// File: rtl/uart_16550_regs_pkg.sv
// Shared UART definitions: transmit state encoding, oversample ratio and stop-bit lengths.
// Used by the transmit path; the RX path reuses the same constants.
package uart_16550_regs_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    localparam int UART_OVERSAMPLE   = 16;
    localparam int UART_STOP_TICKS_1 = 16;
    localparam int UART_STOP_TICKS_1P5 = 24;
    localparam int UART_STOP_TICKS_2 = 32;

    // Index of the final baud tick of the stop period for the latched LCR settings.
    function automatic logic [5:0] uart_stop_last_tick(input logic stb, input logic [1:0] wls);
        if (!stb) begin
            return 6'(UART_STOP_TICKS_1 - 1);
        end else if (wls == 2'd0) begin
            return 6'(UART_STOP_TICKS_1P5 - 1);
        end
        return 6'(UART_STOP_TICKS_2 - 1);
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Write/status bus between the register front end (master) and the transmit path (slave).
interface uart_tx_if #(
    parameter int CNT_W = 5
);
    logic             wr_en;
    logic [7:0]       wr_data;
    logic             tx_ready;
    logic             thr_empty;
    logic             tx_empty;
    logic [CNT_W-1:0] tx_count;

    modport master (
        output wr_en,
        output wr_data,
        input  tx_ready,
        input  thr_empty,
        input  tx_empty,
        input  tx_count
    );

    modport slave (
        input  wr_en,
        input  wr_data,
        output tx_ready,
        output thr_empty,
        output tx_empty,
        output tx_count
    );
endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with push/pop/clear; a push into a full FIFO is accepted only
// when a pop frees a slot in the same cycle. Shared by the TX and RX paths.
module uart_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              clr_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] dout_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              full_o,
    output logic              empty_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 16550 transmit path: THR buffer plus start/data/parity/stop serializer on 16x baud ticks.
// Define UART_TX_FIFO_EN to build the FIFO_DEPTH-entry FIFO; otherwise a single holding register.
module uart_tx
    import uart_16550_regs_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_tick,
    input  logic [1:0] wls,
    input  logic       stb,
    input  logic       pen,
    input  logic       eps,
    input  logic       stick,
    input  logic       set_break,
    input  logic       fifo_en,
    input  logic       tx_fifo_clr,
    output logic       tx,
    uart_tx_if.slave   bus
);
    localparam logic [3:0] TICK_LAST = 4'(UART_OVERSAMPLE - 1);

    uart_tx_state_t   state_q, state_d;
    logic [3:0]       tick_q, tick_d;
    logic [2:0]       bit_q, bit_d;
    logic             tx_q, tx_d;
    logic [7:0]       shift_q, shift_d;
    logic [1:0]       wls_q, wls_d;
    logic             stb_q, stb_d;
    logic             pen_q, pen_d;
    logic             par_q, par_d;

    logic             fifo_pop;
    logic             fifo_push;
    logic             fifo_empty;
    logic [7:0]       fifo_dout;
    logic [CNT_W-1:0] fifo_count;

    function automatic logic calc_parity(input logic [7:0] d, input logic [1:0] w,
                                         input logic e, input logic s);
        logic [7:0] mask;
        logic       x;
        mask = 8'hFF >> (2'd3 - w);
        x    = ^(d & mask);
        if (s) begin
            return ~e;
        end
        return e ? x : ~x;
    endfunction

`ifdef UART_TX_FIFO_EN
    logic fifo_en_q;
    logic fifo_clr;
    logic fifo_full;

    // A change of fifo_en is detected against last cycle's value and flushes the buffer.
    always_ff @(posedge clk) begin
        fifo_en_q <= fifo_en;
    end

    assign fifo_clr  = tx_fifo_clr || (fifo_en != fifo_en_q);
    assign fifo_push = bus.wr_en && !fifo_clr &&
                       (fifo_en ? (!fifo_full || fifo_pop) : (fifo_empty || fifo_pop));

    uart_sync_fifo #(
        .DATA_W (8),
        .DEPTH  (FIFO_DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .clr_i   (fifo_clr),
        .din_i   (bus.wr_data),
        .dout_o  (fifo_dout),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bus.tx_ready = fifo_en ? !fifo_full : fifo_empty;
`else
    logic [7:0] hold_q;
    logic       hold_vld_q;
    logic       unused_fifo_ctrl;

    assign unused_fifo_ctrl = fifo_en ^ tx_fifo_clr;
    assign fifo_push        = bus.wr_en && (!hold_vld_q || fifo_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_vld_q <= 1'b0;
        end else if (fifo_push) begin
            hold_vld_q <= 1'b1;
        end else if (fifo_pop) begin
            hold_vld_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            hold_q <= bus.wr_data;
        end
    end

    assign fifo_dout    = hold_q;
    assign fifo_empty   = !hold_vld_q;
    assign fifo_count   = CNT_W'(hold_vld_q);
    assign bus.tx_ready = !hold_vld_q;
`endif

    assign bus.thr_empty = fifo_empty;
    assign bus.tx_empty  = fifo_empty && (state_q == IDLE);
    assign bus.tx_count  = fifo_count;
    assign tx            = tx_q;

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        wls_d    = wls_q;
        stb_d    = stb_q;
        pen_d    = pen_q;
        par_d    = par_q;
        fifo_pop = 1'b0;
        tx_d     = 1'b1;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    wls_d    = wls;
                    stb_d    = stb;
                    pen_d    = pen;
                    par_d    = calc_parity(fifo_dout, wls, eps, stick);
                    tick_d   = '0;
                    bit_d    = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (baud_tick) begin
                    tick_d = tick_q + 4'd1;
                    if (tick_q == TICK_LAST) begin
                        bit_d   = '0;
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (baud_tick) begin
                    tick_d = tick_q + 4'd1;
                    if (tick_q == TICK_LAST) begin
                        shift_d = shift_q >> 1;
                        if (bit_q == (3'd4 + {1'b0, wls_q})) begin
                            bit_d   = '0;
                            state_d = pen_q ? PARITY : STOP;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    tick_d = tick_q + 4'd1;
                    if (tick_q == TICK_LAST) begin
                        bit_d   = '0;
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                // Stop periods exceed one bit, so bit_q extends the tick counter here.
                if (baud_tick) begin
                    tick_d = tick_q + 4'd1;
                    if ({bit_q[1:0], tick_q} == uart_stop_last_tick(stb_q, wls_q)) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = IDLE;
                    end else if (tick_q == TICK_LAST) begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
        if (set_break) begin
            tx_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        wls_q   <= wls_d;
        stb_q   <= stb_d;
        pen_q   <= pen_d;
        par_q   <= par_d;
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: frame-level model (byte queue expanded into per-tick line levels)
// compared every cycle, plus directed frames with hand-computed bit sequences.
module tb_uart_tx;
    localparam int FIFO_DEPTH = 16;
    localparam int CNT_W      = 5;
`ifdef UART_TX_FIFO_EN
    localparam bit FIFO_BUILD = 1'b1;
`else
    localparam bit FIFO_BUILD = 1'b0;
`endif
    localparam int CAP16 = FIFO_BUILD ? FIFO_DEPTH : 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_tick = 1'b0;
    logic [1:0] wls = 2'd3;
    logic       stb = 1'b0;
    logic       pen = 1'b0;
    logic       eps = 1'b0;
    logic       stick = 1'b0;
    logic       set_break = 1'b0;
    logic       fifo_en = 1'b1;
    logic       tx_fifo_clr = 1'b0;
    logic       tx;

    uart_tx_if #(.CNT_W(CNT_W)) bus ();

    uart_tx #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .baud_tick   (baud_tick),
        .wls         (wls),
        .stb         (stb),
        .pen         (pen),
        .eps         (eps),
        .stick       (stick),
        .set_break   (set_break),
        .fifo_en     (fifo_en),
        .tx_fifo_clr (tx_fifo_clr),
        .tx          (tx),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) begin
                $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
            end
        end
    endtask

    // Baud tick every other clock, gateable to test that the frame holds.
    bit tick_en = 1'b1;
    int bdiv = 0;
    always @(posedge clk) begin
        #1;
        bdiv      = (bdiv + 1) % 2;
        baud_tick = tick_en && (bdiv == 0);
    end

    // Model: queue of bytes awaiting transmission and the remaining line levels of
    // the frame in flight, one entry per baud tick.
    logic [7:0] mq[$];
    logic       wave[$];
    logic       prev_en = 1'b1;
    logic       exp_tx = 1'b1;
    logic       m_clr;

    function automatic int cap_of(input logic fe);
        return (FIFO_BUILD && fe) ? FIFO_DEPTH : 1;
    endfunction

    task automatic build_frame(input logic [7:0] d);
        int   nb;
        int   nstop;
        logic par;
        nb  = 5 + int'(wls);
        par = 1'b0;
        for (int k = 0; k < nb; k++) par = par ^ d[k];
        if (stick) par = ~eps;
        else if (!eps) par = ~par;
        nstop = !stb ? 16 : ((wls == 2'd0) ? 24 : 32);
        for (int i = 0; i < 16; i++) wave.push_back(1'b0);
        for (int k = 0; k < nb; k++)
            for (int i = 0; i < 16; i++) wave.push_back(d[k]);
        if (pen)
            for (int i = 0; i < 16; i++) wave.push_back(par);
        for (int i = 0; i < nstop; i++) wave.push_back(1'b1);
    endtask

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            wave.delete();
            prev_en = fifo_en;
            exp_tx  = 1'b1;
        end else begin
            m_clr   = FIFO_BUILD && (tx_fifo_clr || (fifo_en != prev_en));
            prev_en = fifo_en;
            if (wave.size() == 0) begin
                if (mq.size() > 0) build_frame(mq.pop_front());
            end else if (baud_tick) begin
                void'(wave.pop_front());
            end
            if (m_clr) mq.delete();
            else if (bus.wr_en && mq.size() < cap_of(fifo_en)) mq.push_back(bus.wr_data);
            exp_tx = set_break ? 1'b0 : ((wave.size() > 0) ? wave[0] : 1'b1);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check("tx_in_reset", tx, 1);
        end else begin
            check("tx", tx, exp_tx);
            check("tx_count", bus.tx_count, mq.size());
            check("thr_empty", bus.thr_empty, mq.size() == 0);
            check("tx_empty", bus.tx_empty, (mq.size() == 0) && (wave.size() == 0));
            check("tx_ready", bus.tx_ready, mq.size() < cap_of(fifo_en));
        end
    end

    logic last_tick;

    task automatic step();
        @(posedge clk);
        last_tick = baud_tick;
        #1;
    endtask

    task automatic write(input logic [7:0] b);
        bus.wr_en   = 1'b1;
        bus.wr_data = b;
        step();
        bus.wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!bus.tx_empty && n < budget) begin
            step();
            n++;
        end
        check("wait_idle_timeout", bus.tx_empty, 1);
    endtask

    task automatic wait_tx_low(input string nm);
        int n = 0;
        while (tx !== 1'b0 && n < 20) begin
            step();
            n++;
        end
        check({nm, "_start_low"}, tx, 0);
    endtask

    task automatic wait_ticks(input int nt);
        int t = 0;
        int n = 0;
        while (t < nt && n < 8 * nt + 100) begin
            step();
            n++;
            if (last_tick) t++;
        end
    endtask

    // Samples the line mid-bit (tick 8 of every 16) and counts ticks until TEMT.
    task automatic check_frame(input string nm, input logic [7:0] b, input logic [15:0] bits,
                               input int nsamp, input int exp_ticks);
        int ticks = 0;
        int n = 0;
        write(b);
        check({nm, "_count_after_wr"}, bus.tx_count, 1);
        wait_tx_low(nm);
        while (!bus.tx_empty && n < 4 * exp_ticks + 200) begin
            step();
            n++;
            if (last_tick) begin
                ticks++;
                if ((ticks % 16) == 8 && (ticks / 16) < nsamp)
                    check($sformatf("%s_bit%0d", nm, ticks / 16), tx, bits[ticks / 16]);
            end
        end
        check({nm, "_ticks"}, ticks, exp_ticks);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int brk_ticks;
        int n;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        repeat (3) step();
        check("rst_tx", tx, 1);
        check("rst_tx_ready", bus.tx_ready, 1);
        check("rst_thr_empty", bus.thr_empty, 1);
        check("rst_tx_empty", bus.tx_empty, 1);
        check("rst_tx_count", bus.tx_count, 0);
        rst = 1'b0;
        repeat (3) step();

        // 8N1, 0xA5: 0,1,0,1,0,0,1,0,1 then stop 1; 160 ticks
        wls = 2'd3; pen = 1'b0; stb = 1'b0;
        check_frame("8n1", 8'hA5, 16'h034A, 10, 160);

        // 5 bits even parity, 1.5 stop, 0x13: 0,1,1,0,0,1,P=1,stop; 136 ticks
        wls = 2'd0; pen = 1'b1; eps = 1'b1; stb = 1'b1; stick = 1'b0;
        check_frame("5e15", 8'h13, 16'h00E6, 8, 136);
        stick = 1'b1;
        check_frame("5s15", 8'h13, 16'h00A6, 8, 136);
        stick = 1'b0;

        // Mixed settings, mid-frame LCR change and a baud-tick stall
        wls = 2'd2; pen = 1'b1; eps = 1'b0; stb = 1'b1;
        write(8'h5C);
        write(8'h3F);
        write(8'hC1);
        wait_tx_low("mix");
        wls = 2'd3; pen = 1'b0; stb = 1'b0;
        wait_ticks(20);
        tick_en = 1'b0;
        repeat (40) step();
        tick_en = 1'b1;
        wait_idle(20000);

        // Fill while a frame is in flight: capacity reached, overflow dropped
        fifo_en = 1'b1;
        write(8'h01);
        wait_tx_low("fill");
        for (int i = 0; i < 17; i++) begin
            write(8'(8'h80 + i));
            check($sformatf("fill_ready_%0d", i), bus.tx_ready, (i + 1) < CAP16);
            check($sformatf("fill_count_%0d", i), bus.tx_count, ((i + 1) < CAP16) ? (i + 1) : CAP16);
        end
        wait_idle(15000);

        // Holding-register mode
        fifo_en = 1'b0;
        repeat (3) step();
        write(8'h11);
        wait_tx_low("hold");
        write(8'h22);
        check("hold_thr_empty", bus.thr_empty, 0);
        check("hold_ready", bus.tx_ready, 0);
        write(8'h33);
        check("hold_drop_count", bus.tx_count, 1);
        n = 0;
        while (bus.tx_count != 0 && n < 2000) begin
            step();
            n++;
        end
        check("hold_popped_thr_empty", bus.thr_empty, 1);
        wait_idle(5000);
        fifo_en = 1'b1;
        repeat (3) step();

        // Break mid-frame: line held low, frame timing unchanged
        write(8'hFF);
        wait_tx_low("brk");
        brk_ticks = 0;
        n = 0;
        while (brk_ticks < 40 && n < 500) begin
            step();
            n++;
            if (last_tick) brk_ticks++;
        end
        set_break = 1'b1;
        n = 0;
        while (!bus.tx_empty && n < 2000) begin
            step();
            n++;
            if (last_tick) brk_ticks++;
        end
        check("brk_line_low", tx, 0);
        check("brk_ticks", brk_ticks, 160);
        set_break = 1'b0;
        step();
        check("brk_release", tx, 1);

        // Flush with queued bytes; a write in the clear cycle is discarded
        for (int i = 0; i < 6; i++) write(8'(8'h40 + i));
        check("flush_before", bus.tx_count, FIFO_BUILD ? 5 : 1);
        tx_fifo_clr = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h99;
        step();
        tx_fifo_clr = 1'b0;
        bus.wr_en   = 1'b0;
        check("flush_after", bus.tx_count, FIFO_BUILD ? 0 : 1);
        wait_idle(5000);

        // Reset during DATA
        write(8'h5A);
        write(8'h6B);
        write(8'h7C);
        wait_tx_low("rstmid");
        wait_ticks(30);
        #2;
        rst = 1'b1;
        #1;
        check("rstmid_tx", tx, 1);
        check("rstmid_count", bus.tx_count, 0);
        check("rstmid_tx_empty", bus.tx_empty, 1);
        step();
        step();
        rst = 1'b0;
        repeat (400) step();
        check("rstmid_idle_tx", tx, 1);
        check("rstmid_idle_empty", bus.tx_empty, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Transmit path of the 16550 UART, directly downstream of the AXI4-Lite register front end. It accepts byte writes to THR (`wr_en`/`wr_data`), buffers them in a transmit FIFO, and serializes each byte onto `tx` as start / 5–8 data / optional parity / stop bits. Bit timing comes from a 16x-oversample `baud_tick` produced by the baud generator. Status outputs feed LSR.THRE, LSR.TEMT and the front end's `tx_ready` input.

## Interface
- `FIFO_DEPTH`, default 16: transmit FIFO entries; power of two, ≥2.
- `CNT_W`, default `$clog2(FIFO_DEPTH)+1`: width of `tx_count`.

Clock and reset: one clock, `clk`; reset `rst` is asynchronous and active-high.

- `clk` in 1: system clock.
- `rst` in 1: asynchronous active-high reset.
- `baud_tick` in 1: one-cycle pulse at 16x baud rate.
- `wr_en` in 1: THR write strobe, one cycle per byte.
- `wr_data` in 8: byte to transmit.
- `wls` in 2: LCR[1:0]; data bits = 5 + `wls`.
- `stb` in 1: LCR[2]; stop-bit select.
- `pen` in 1: LCR[3]; parity enable.
- `eps` in 1: LCR[4]; even-parity select.
- `stick` in 1: LCR[5]; stick parity.
- `set_break` in 1: LCR[6]; forces `tx` low.
- `fifo_en` in 1: FCR[0]; 0 = single-byte holding-register mode.
- `tx_fifo_clr` in 1: FCR[2] pulse; flushes the FIFO.
- `tx` out 1: serial output, registered.
- `tx_ready` out 1: FIFO can accept a write.
- `thr_empty` out 1: FIFO/holding register empty (LSR.THRE).
- `tx_empty` out 1: FIFO empty and shifter idle (LSR.TEMT).
- `tx_count` out CNT_W: bytes currently held.

## Operation
- **Capacity.** Effective capacity is `FIFO_DEPTH` when `fifo_en`=1, otherwise 1. `tx_ready` = count < capacity.
- **Writes.** A write while full is silently dropped; FIFO contents and count are unchanged.
- **States.** The state machine uses `IDLE`, `START`, `DATA`, `PARITY`, `STOP`.
- **IDLE.** If the FIFO is non-empty, pop the head into the shift register. In the same cycle, latch `wls`/`stb`/`pen`/`eps`/`stick`, clear the tick counter, and go to `START`. LCR changes mid-frame take effect only at the next load.
- **Bit timing.** Each bit lasts 16 `baud_tick`s, counted by a 4-bit tick counter.
- **START.** `tx`=0.
- **DATA.** Data bits go out LSB first; a bit counter runs to 5+`wls`. Then go to `PARITY` if `pen`, else `STOP`.
- **Parity bit:**
  - `stick`=0: even parity when `eps`=1, odd when `eps`=0.
  - `stick`=1: the bit is `~eps`.
- **Stop bits:**
  - 1 bit (16 ticks) when `stb`=0.
  - 1.5 bits (24 ticks) when `stb`=1 and `wls`=0.
  - 2 bits (32 ticks) otherwise.
- **End of STOP.** Return to `IDLE`. Back-to-back frames have no idle gap: the next byte loads in the cycle after STOP ends.
- **Break.** `set_break` forces `tx`=0 without disturbing the state machine.
- **Flush.** `tx_fifo_clr` empties the FIFO in one cycle; a frame in the shifter completes normally. A write in the same cycle as `tx_fifo_clr` is discarded.
- **Simultaneous write and pop.** Count is unchanged and both operations take effect. When full, the pop first frees a slot, so the write is accepted.
- **Changing `fifo_en`.** A change of `fifo_en` flushes the FIFO, matching 16550 behaviour.

## Timing
- **Reset values:** `tx`=1, `tx_ready`=1, `thr_empty`=1, `tx_empty`=1, `tx_count`=0, state `IDLE`, counters 0.
- **Write to count:** `tx_count`/`thr_empty` update the cycle after `wr_en`.
- **Write to start bit:** when idle and empty, the write is popped 1 cycle later and `tx` falls 1 cycle after that (2 cycles after `wr_en`).
- **Frame length** (in `baud_tick`s): 16 × (1 + data + parity) + stop ticks.
- **`tx_empty`** rises the cycle after the final stop tick, provided the FIFO is empty.
- **Reset mid-frame:** the frame is aborted, `tx`=1 immediately (asynchronous), and FIFO contents are lost.
- **No `baud_tick`:** the state machine holds in its current bit indefinitely.

## Configuration
- **`UART_TX_FIFO_EN` defined:** FIFO of `FIFO_DEPTH` entries; `fifo_en` selects capacity as described above.
- **`UART_TX_FIFO_EN` undefined:**
  - Only a single holding register is built (16450 behaviour).
  - `fifo_en` and `tx_fifo_clr` are ignored.
  - Capacity is 1; `tx_count` is 0 or 1.

## Structure
- **`uart_16550_regs_pkg`** gains the following shared definitions:
  - `uart_tx_state_t` enum;
  - `UART_OVERSAMPLE` = 16;
  - stop-tick constants 16/24/32.
- **`uart_sync_fifo` sub-module:** parameterized width and depth, with push, pop, clear, count, full and empty. It is written so that the RX path can reuse it.

## Test plan
- **Basic 8N1:** `wls`=3, `pen`=0, `stb`=0, write 0xA5 → `tx` shows 0, then 1,0,1,0,0,1,0,1, then 1; 160 ticks total; `tx_empty` rises afterwards.
- **Parity and stop:** `wls`=0, `pen`=1, `eps`=1, `stb`=1, write 0x13 → 5 data bits 1,1,0,0,1, parity 1, stop 24 ticks. Repeat with `stick`=1, `eps`=1 → parity bit 0.
- **FIFO fill:** write 17 bytes back-to-back with `fifo_en`=1 → `tx_ready` falls at count 16, the 17th byte is dropped, and 16 frames go out back-to-back with no idle gap.
- **Holding-register mode:** `fifo_en`=0, write twice without waiting → second write dropped, `thr_empty`=0 until the first pop.
- **Break and flush:** assert `set_break` mid-frame → `tx`=0 throughout while the frame timing continues. Pulse `tx_fifo_clr` with 5 queued bytes → count becomes 0 and only the current frame completes.
- **Reset mid-frame:** assert `rst` during DATA → `tx`=1 immediately, `tx_count`=0, and after release no frame starts without a new write.
